// File: rtl/addsub_seq_if.sv
// addsub_seq_if: request/response bundle for the digit-serial adder-subtracter.
//   master: drives start, a, b, sub; observes busy, done, result and flags.
//   slave : the arithmetic unit side.
// WIDTH must match the WIDTH of the attached addsub_seq.
interface addsub_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             negative;
  logic             overflow;

  modport master (
    output start, a, b, sub,
    input  busy, done, result, carry, zero, negative, overflow
  );

  modport slave (
    input  start, a, b, sub,
    output busy, done, result, carry, zero, negative, overflow
  );
endinterface

// File: rtl/addsub_seq.sv
// addsub_seq: digit-serial two's-complement adder-subtracter with ALU flags.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, aborts any operation
//   bus   : addsub_seq_if.slave
//           start/a/b/sub  request, captured only when idle
//           busy           operation in progress
//           done           one-cycle pulse when result/flags update
//           result, carry, zero, negative, overflow  last completed op
// DIGIT bits are processed per clock, LSB digit first, so an operation
// takes NDIG = WIDTH/DIGIT cycles. WIDTH >= 2, DIGIT must divide WIDTH.
module addsub_seq #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  addsub_seq_if.slave   bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic {IDLE, RUN} state_e;

  state_e state_q, state_d;

  // Operand shift registers: the active digit always sits in the low bits.
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cy_q, cy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  // Architecturally visible outputs, only touched on completion.
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] dig_w;
  logic [WIDTH-1:0] acc_next;
  logic             cin_msb;
  logic             last;

  // DIGIT-wide slice adder.
  assign dsum     = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, cy_q};
  // Carry into the top bit of the slice: recovered from the sum bit and its
  // operand bits. On the last digit this is the carry into bit WIDTH-1.
  assign cin_msb  = dsum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
  assign last     = (cnt_q == CW'(NDIG - 1));
  // New digit enters from the MSB side; after NDIG shifts the LSB digit
  // has arrived at bit 0.
  assign dig_w    = WIDTH'(dsum[DIGIT-1:0]);
  assign acc_next = (acc_q >> DIGIT) | (dig_w << (WIDTH - DIGIT));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy     = (state_q == RUN);
    bus.done     = done_q;
    bus.result   = res_q;
    bus.carry    = carry_q;
    bus.zero     = zero_q;
    bus.negative = neg_q;
    bus.overflow = ovf_q;
  end

  // Datapath next-state
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    res_d   = res_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Subtract is A + ~B + 1: invert B here, feed sub as carry-in.
          a_d   = bus.a;
          b_d   = bus.b ^ {WIDTH{bus.sub}};
          cy_d  = bus.sub;
          cnt_d = '0;
          acc_d = '0;
        end
      end
      RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        cy_d  = dsum[DIGIT];
        cnt_d = cnt_q + CW'(1);
        acc_d = acc_next;
        if (last) begin
          res_d   = acc_next;
          carry_d = dsum[DIGIT];
          zero_d  = (acc_next == '0);
          neg_d   = acc_next[WIDTH-1];
          ovf_d   = cin_msb ^ dsum[DIGIT];
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_addsub_seq.sv
// tb_addsub_seq: scoreboard bench for addsub_seq, two configurations:
//   u8  WIDTH=8,  DIGIT=4 (2 cycles per op)
//   u16 WIDTH=16, DIGIT=1 (16 cycles per op)
// Stimulus pushes expected results (value, flags, completion cycle) computed
// with plain integer arithmetic; a monitor pops and compares on every done.
module tb_addsub_seq;
  typedef struct {
    logic [15:0] res;
    logic        c, z, n, v;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // High in the cycle following an edge that sampled reset.
  logic rst_seen = 1'b1;
  always @(posedge clk) rst_seen <= ~rst_n;

  int tests = 0;
  int fails = 0;
  exp_t q8[$];
  exp_t q16[$];

  addsub_seq_if #(.WIDTH(8))  if8 ();
  addsub_seq_if #(.WIDTH(16)) if16 ();

  addsub_seq #(.WIDTH(8),  .DIGIT(4)) u8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  addsub_seq #(.WIDTH(16), .DIGIT(1)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: integer arithmetic on the unsigned and signed views.
  function automatic exp_t model(input int w, input int a, input int b, input bit s);
    exp_t e;
    int m, u, r, sa, sb, sm;
    m  = 1 << w;
    u  = s ? a - b : a + b;
    r  = ((u % m) + m) % m;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    sm = s ? sa - sb : sa + sb;
    e.res = 16'(r);
    e.c   = s ? (a >= b) : (a + b >= m);
    e.z   = (r == 0);
    e.n   = (r >= m / 2);
    e.v   = (sm >= m / 2) || (sm < -(m / 2));
    e.cyc = 0;
    return e;
  endfunction

  // Monitor: reset state, hold-during-RUN, and scoreboard compare on done.
  initial begin
    logic [15:0] prev8, prev16;
    exp_t e;
    prev8  = '0;
    prev16 = '0;
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        chk("reset8",  32'({if8.busy, if8.done, if8.result, if8.carry, if8.zero,
                            if8.negative, if8.overflow}), 32'd0);
        chk("reset16", 32'({if16.busy, if16.done, if16.result, if16.carry, if16.zero,
                            if16.negative, if16.overflow}), 32'd0);
        prev8  = '0;
        prev16 = '0;
      end else begin
        if (if8.done) begin
          chk("pending8", 32'(q8.size() > 0), 32'd1);
          if (q8.size() > 0) begin
            e = q8.pop_front();
            chk("result8", 32'({if8.result, if8.carry, if8.zero, if8.negative, if8.overflow}),
                           32'({e.res[7:0], e.c, e.z, e.n, e.v}));
            chk("latency8", 32'(cyc), 32'(e.cyc));
            chk("idle_on_done8", 32'(if8.busy), 32'd0);
            prev8 = e.res;
          end
        end else if (if8.busy) begin
          chk("hold8", 32'(if8.result), 32'(prev8[7:0]));
        end
        if (if16.done) begin
          chk("pending16", 32'(q16.size() > 0), 32'd1);
          if (q16.size() > 0) begin
            e = q16.pop_front();
            chk("result16", 32'({if16.result, if16.carry, if16.zero, if16.negative, if16.overflow}),
                            32'({e.res, e.c, e.z, e.n, e.v}));
            chk("latency16", 32'(cyc), 32'(e.cyc));
            prev16 = e.res;
          end
        end else if (if16.busy) begin
          chk("hold16", 32'(if16.result), 32'(prev16));
        end
      end
    end
  end

  // Called at #1 after an edge; returns at #1 after an edge with the DUT idle.
  task automatic wait_idle(input int w);
    int n;
    n = 0;
    while (((w == 8) ? if8.busy : if16.busy) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", 32'(n < 100), 32'd1);
  endtask

  // Issue one operation; start is held for exactly one edge.
  task automatic op(input int w, input int a, input int b, input bit s);
    exp_t e;
    wait_idle(w);
    e = model(w, a, b, s);
    if (w == 8) begin
      e.cyc = cyc + 1 + 2;
      if8.start = 1'b1; if8.a = 8'(a); if8.b = 8'(b); if8.sub = s;
      q8.push_back(e);
    end else begin
      e.cyc = cyc + 1 + 16;
      if16.start = 1'b1; if16.a = 16'(a); if16.b = 16'(b); if16.sub = s;
      q16.push_back(e);
    end
    @(posedge clk); #1;
    if (w == 8) begin
      if8.start = 1'b0;
      if8.a = 8'($urandom); if8.b = 8'($urandom); if8.sub = 1'($urandom);
      chk("busy8", 32'(if8.busy), 32'd1);
    end else begin
      if16.start = 1'b0;
      if16.a = 16'($urandom); if16.b = 16'($urandom); if16.sub = 1'($urandom);
      chk("busy16", 32'(if16.busy), 32'd1);
    end
  endtask

  initial begin
    exp_t e;
    int c0, n;
    if8.start = 1'b0;  if8.a = '0;  if8.b = '0;  if8.sub = 1'b0;
    if16.start = 1'b0; if16.a = '0; if16.b = '0; if16.sub = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed 8-bit cases
    op(8, 8'h3C, 8'h05, 1'b0);
    op(8, 8'h05, 8'h05, 1'b1);
    op(8, 8'h03, 8'h05, 1'b1);
    op(8, 8'h7F, 8'h01, 1'b0);
    op(8, 8'hFF, 8'h01, 1'b0);
    op(8, 8'h80, 8'h01, 1'b1);
    op(8, 8'h00, 8'h00, 1'b1);

    // Start held through RUN with changed operands (ignored), still high in
    // the done cycle (accepted there).
    wait_idle(8);
    c0 = cyc;
    if8.start = 1'b1; if8.a = 8'h10; if8.b = 8'h20; if8.sub = 1'b0;
    e = model(8, 8'h10, 8'h20, 1'b0); e.cyc = c0 + 3; q8.push_back(e);
    @(posedge clk); #1;
    chk("busy_held8", 32'(if8.busy), 32'd1);
    if8.a = 8'hFF; if8.b = 8'hFF;
    e = model(8, 8'hFF, 8'hFF, 1'b0); e.cyc = c0 + 6; q8.push_back(e);
    repeat (3) begin @(posedge clk); #1; end
    if8.start = 1'b0;

    // Reset mid-RUN: the pending op is dropped and must never complete.
    op(8, 8'h12, 8'h34, 1'b0);
    rst_n = 1'b0;
    void'(q8.pop_back());
    @(posedge clk); #1;
    rst_n = 1'b1;
    op(8, 8'h55, 8'h2A, 1'b1);

    // Randomized 8-bit ops
    for (int i = 0; i < 30; i++)
      op(8, int'($urandom_range(255)), int'($urandom_range(255)), 1'($urandom));

    // 16-bit, one bit per cycle
    op(16, 16'h8000, 16'h0001, 1'b1);
    op(16, 16'hFFFF, 16'h0001, 1'b0);
    for (int i = 0; i < 8; i++)
      op(16, int'($urandom_range(65535)), int'($urandom_range(65535)), 1'($urandom));

    n = 0;
    while ((q8.size() + q16.size()) > 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 32'(q8.size() + q16.size()), 32'd0);
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
